// File: rtl/ex_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : ex_mul_seq
// Brief    : Iterative shift-add integer multiplier for the execute stage.
//            Stalls the pipeline while running and returns one product half.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mul_seq #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      func,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int C_N     = XLEN / BITS_PER_CYCLE;
    localparam int C_CNT_W = (C_N > 1) ? $clog2(C_N) : 1;
    localparam int C_PW    = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] FN_MUL   = 2'b00;
    localparam logic [1:0] FN_MULH  = 2'b01;
    localparam logic [1:0] FN_MULHU = 2'b11;

    logic [1:0]         state_q,  state_d;
    logic [1:0]         func_q,   func_d;
    logic               neg_q,    neg_d;
    logic [C_PW-1:0]    mcand_q,  mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [C_PW-1:0]    acc_q,    acc_d;
    logic [C_CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [C_PW-1:0] w_partial;
    logic [C_PW-1:0] w_acc_sum;
    logic [C_PW-1:0] w_prod;

    // Unsigned XLEN-bit magnitudes hold 2^(XLEN-1) exactly, so the most
    // negative operand needs no extra bit.
    always_comb begin
        w_a_neg = (func != FN_MULHU) & opa[XLEN-1];
        w_b_neg = ((func == FN_MUL) | (func == FN_MULH)) & opb[XLEN-1];
        w_a_mag = w_a_neg ? (~opa + XLEN'(1)) : opa;
        w_b_mag = w_b_neg ? (~opb + XLEN'(1)) : opb;
    end

    always_comb begin
        w_partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                w_partial = w_partial + (mcand_q << i);
            end
        end
        w_acc_sum = acc_q + w_partial;
        w_prod    = neg_q ? (~w_acc_sum + C_PW'(1)) : w_acc_sum;
    end

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    func_d   = func;
                    neg_d    = w_a_neg ^ w_b_neg;
                    mcand_d  = {{XLEN{1'b0}}, w_a_mag};
                    mplier_d = w_b_mag;
                    acc_d    = '0;
                    cnt_d    = C_CNT_W'(C_N - 1);
                    if ((w_a_mag == '0) || (w_b_mag == '0)) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                if (cnt_q == '0) begin
                    result_d = (func_q == FN_MUL) ? w_prod[XLEN-1:0] : w_prod[C_PW-1:XLEN];
                    state_d  = S_DONE;
                end else begin
                    cnt_d    = cnt_q - C_CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A squash abandons the operation without touching the visible result.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_BUSY) | (state_q == S_DONE);
    assign done   = (state_q == S_DONE) & ~flush;
    assign stall  = rst & (((state_q == S_IDLE) & start & ~flush) | (state_q == S_BUSY));
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mul_seq
// Brief    : Directed self-checking bench for ex_mul_seq (BITS_PER_CYCLE=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  func;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          total;
    int          bad;
    logic [31:0] last_exp;

    ex_mul_seq #(
        .XLEN           (32),
        .BITS_PER_CYCLE (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func   (func),
        .opa    (opa),
        .opb    (opb),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Entered and left at posedge+1 with the DUT idle; acceptance is cycle 0.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_cyc, input string name);
        int got;
        bit stall_bad;
        bit busy_bad;
        got       = -1;
        stall_bad = 1'b0;
        busy_bad  = 1'b0;
        func  = f;
        opa   = a;
        opb   = b;
        start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL %s stall_at_accept: got %b required 1", name, stall);
        end
        for (int c = 1; c <= exp_cyc + 5; c++) begin
            @(posedge clk);
            #1;
            if (stall !== (c < exp_cyc)) stall_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                got = c;
                break;
            end
            if (c == 1) begin
                opa = a ^ 32'h5A5A_A5A5;
                opb = b ^ 32'h0F0F_F0F0;
            end
        end
        total++;
        if (got != exp_cyc) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d required %0d", name, got, exp_cyc);
        end
        total++;
        if (got < 0 || result !== exp) begin
            bad++;
            $display("FAIL %s result: got %h required %h", name, result, exp);
        end
        total++;
        if (stall_bad) begin
            bad++;
            $display("FAIL %s stall_profile: got wrong stall in cycles 1..%0d required high until done", name, exp_cyc);
        end
        total++;
        if (busy_bad) begin
            bad++;
            $display("FAIL %s busy_profile: got busy low before done required 1", name);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: got done=%b busy=%b required 0 0", name, done, busy);
        end
        last_exp = exp;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        flush = 1'b0;
        func  = 2'b00;
        opa   = 32'd1;
        opb   = 32'd1;
        #2;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_values: got busy=%b done=%b stall=%b result=%h required 0 0 0 0",
                     busy, done, stall, result);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: got busy=%b done=%b required 0 0", busy, done);
        end
        last_exp = 32'h0;
    endtask

    task automatic test_mul_basic();
        run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, 33, "mul_7x6");
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33, "mul_neg2x3");
    endtask

    task automatic test_signed_corners();
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_m1xm1");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1xm1");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min_x_min");
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1xmax");
        run_op(2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu_min_x2");
    endtask

    task automatic test_zero_shortcut();
        run_op(2'b11, 32'h1234_5678, 32'h0, 32'h0, 1, "zero_mulhu");
        run_op(2'b01, 32'h0, 32'h8000_0000, 32'h0, 1, "zero_mulh_a");
    endtask

    // Back-to-back: each op is accepted in the cycle right after the previous DONE+1.
    task automatic test_back_to_back();
        run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, "b2b_first");
        run_op(2'b00, 32'h0001_0001, 32'h0000_0100, 32'h0100_0100, 33, "b2b_second");
    endtask

    task automatic test_flush();
        bit saw_done;
        saw_done = 1'b0;
        func  = 2'b00;
        opa   = 32'h0000_1234;
        opb   = 32'h0000_0010;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        flush = 1'b1;
        #1;
        if (done === 1'b1) saw_done = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_busy_cleared: got %b required 0", busy);
        end
        total++;
        if (saw_done || done !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_done: got done pulse=%b required 0", saw_done | done);
        end
        total++;
        if (result !== last_exp) begin
            bad++;
            $display("FAIL flush_result_kept: got %h required %h", result, last_exp);
        end
        run_op(2'b00, 32'd3, 32'd5, 32'd15, 33, "after_flush_3x5");
    endtask

    task automatic test_async_reset();
        func  = 2'b00;
        opa   = 32'h0000_0100;
        opb   = 32'h0000_0100;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
        end
        #4;
        total++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            bad++;
            $display("FAIL async_pre_busy: got busy=%b stall=%b required 1 1", busy, stall);
        end
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_ctrl: got busy=%b done=%b stall=%b required 0 0 0", busy, done, stall);
        end
        total++;
        if (result !== 32'h0) begin
            bad++;
            $display("FAIL async_rst_result: got %h required 00000000", result);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_release_idle: got busy=%b done=%b required 0 0", busy, done);
        end
        last_exp = 32'h0;
        run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, "after_rst_mulhu");
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        last_exp = 32'h0;
        rst      = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        func     = 2'b00;
        opa      = 32'h0;
        opb      = 32'h0;
        test_reset();
        test_mul_basic();
        test_signed_corners();
        test_zero_shortcut();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
